// File: rtl/tdm_demux_1x2_pkg.sv
// Shared definitions for the 1:2 TDM demultiplexer: slot-tracking states and
// default datapath widths.
package tdm_demux_1x2_pkg;

  // Default sample width and completed-frame counter width.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  // Slot-tracking state, fixed 2-bit encoding.
  typedef enum logic [1:0] {
    ST_HUNT     = 2'd0,
    ST_EXPECT_A = 2'd1,
    ST_EXPECT_B = 2'd2
  } slot_state_e;

  // True when the tracker holds frame alignment.
  function automatic logic is_locked(input slot_state_e st);
    return (st != ST_HUNT);
  endfunction

endpackage

// File: rtl/tdm_demux_1x2_slot_fsm.sv
// Slot tracker: follows the A/B slot order of the incoming stream using the
// sync marker and issues single-cycle capture / error / frame strobes.
module tdm_demux_1x2_slot_fsm
  import tdm_demux_1x2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_sync,
  output slot_state_e state,
  output logic        capture_a,
  output logic        capture_b,
  output logic        err,
  output logic        frame_inc
);

  slot_state_e state_q;
  slot_state_e state_d;

  // State register; reset returns to hunting for a sync marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; idle cycles leave everything untouched.
  always_comb begin
    state_d   = state_q;
    capture_a = 1'b0;
    capture_b = 1'b0;
    err       = 1'b0;
    frame_inc = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          // Non-sync samples are dropped until a marker is seen.
          if (in_sync) begin
            capture_a = 1'b1;
            state_d   = ST_EXPECT_B;
          end
        end
        ST_EXPECT_A: begin
          if (in_sync) begin
            capture_a = 1'b1;
            state_d   = ST_EXPECT_B;
          end else begin
            // Alignment lost: drop the sample and start hunting again.
            err     = 1'b1;
            state_d = ST_HUNT;
          end
        end
        ST_EXPECT_B: begin
          if (in_sync) begin
            // B slot missing: treat this sample as the new A, keep waiting for B.
            err       = 1'b1;
            capture_a = 1'b1;
            state_d   = ST_EXPECT_B;
          end else begin
            capture_b = 1'b1;
            frame_inc = 1'b1;
            state_d   = ST_EXPECT_A;
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: rtl/tdm_demux_1x2.sv
// 1:2 TDM demultiplexer: steers an A,B,A,B sample stream onto two registered
// channel outputs, tracks framing via the sync marker, flags slot errors and
// counts completed frames.
module tdm_demux_1x2
  import tdm_demux_1x2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sync,
  output logic [WIDTH-1:0] out_a,
  output logic             out_a_valid,
  output logic [WIDTH-1:0] out_b,
  output logic             out_b_valid,
  output logic             sync_err,
  output logic             locked,
  output logic [CNT_W-1:0] frame_cnt
);

  slot_state_e state;
  logic        capture_a;
  logic        capture_b;
  logic        err;
  logic        frame_inc;

  logic [WIDTH-1:0] out_a_q;
  logic [WIDTH-1:0] out_b_q;
  logic             out_a_valid_q;
  logic             out_b_valid_q;
  logic             sync_err_q;
  logic [CNT_W-1:0] frame_cnt_q;

  tdm_demux_1x2_slot_fsm u_slot_fsm (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .state     (state),
    .capture_a (capture_a),
    .capture_b (capture_b),
    .err       (err),
    .frame_inc (frame_inc)
  );

  // Channel data registers: hold the last captured sample of each channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      if (capture_a) begin
        out_a_q <= in_data;
      end
      if (capture_b) begin
        out_b_q <= in_data;
      end
    end
  end

  // Single-cycle pulses registered from the tracker strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_a_valid_q <= 1'b0;
      out_b_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      out_a_valid_q <= capture_a;
      out_b_valid_q <= capture_b;
      sync_err_q    <= err;
    end
  end

  // Completed-frame counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_inc) begin
      frame_cnt_q <= frame_cnt_q + CNT_W'(1);
    end
  end

  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_a_valid = out_a_valid_q;
  assign out_b_valid = out_b_valid_q;
  assign sync_err    = sync_err_q;
  assign frame_cnt   = frame_cnt_q;
  // State is itself a register, so this decode is glitch-free and valid the
  // cycle after the first accepted sync.
  assign locked      = is_locked(state);

endmodule
